divide8_unsigned_sequential: RTL and testbench

Sequential 8-bit unsigned restoring divider. It is the inverse-operation companion to the 8-bit unsigned Wallace-tree multiplier in the same arithmetic library. It computes quotient and remainder one bit per clock under a start/done handshake. It feeds the same datapath users and lets benches check round trips: a*b divided by b must return a with remainder 0.

---
 rtl/divide8_pkg.sv | 16 +
 rtl/divide8_step.sv | 23 ++
 rtl/divide8_unsigned_sequential.sv | 102 ++++++++++
 tb/tb_divide8_unsigned_sequential.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/divide8_pkg.sv
// Shared constants and state encoding for the 8-bit sequential restoring divider.
package divide8_pkg;

  localparam int DIV_W = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [DIV_W-1:0] DIV0_QUOTIENT = 8'hFF;
  localparam logic [CNT_W-1:0] LAST_ITER     = 3'(DIV_W - 1);

endpackage

// File: rtl/divide8_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module divide8_step
  import divide8_pkg::*;
(
  input  logic [DIV_W-1:0] rem,
  input  logic             msb,
  input  logic [DIV_W-1:0] dvs,
  output logic [DIV_W-1:0] rem_next,
  output logic             qbit
);

  logic [DIV_W:0] t;
  logic [DIV_W:0] diff;

  // rem < dvs on entry, so t < 2*dvs and bit DIV_W of the 9-bit difference is exactly the borrow.
  always_comb begin
    t        = {rem, msb};
    diff     = t - {1'b0, dvs};
    qbit     = ~diff[DIV_W];
    rem_next = qbit ? diff[DIV_W-1:0] : t[DIV_W-1:0];
  end

endmodule

// File: rtl/divide8_unsigned_sequential.sv
// 8-bit unsigned restoring divider, one quotient bit per clock under a start/done handshake.
module divide8_unsigned_sequential
  import divide8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [DIV_W-1:0] dvd_q;
  logic [DIV_W-1:0] dvs_q;
  logic [DIV_W-1:0] rem_q;
  logic [DIV_W-1:0] quotient_q;
  logic [DIV_W-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [DIV_W-1:0] rem_d;
  logic             qbit_d;

  divide8_step u_step (
    .rem      (rem_q),
    .msb      (dvd_q[DIV_W-1]),
    .dvs      (dvs_q),
    .rem_next (rem_d),
    .qbit     (qbit_d)
  );

  // The partial remainder never exceeds the divisor, so its always-zero ninth bit is not stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (divisor != '0) begin
              dvd_q   <= dividend;
              dvs_q   <= divisor;
              rem_q   <= '0;
              count_q <= '0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end else begin
              quotient_q  <= DIV0_QUOTIENT;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          dvd_q   <= {dvd_q[DIV_W-2:0], qbit_d};
          rem_q   <= rem_d;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_ITER) begin
            quotient_q  <= {dvd_q[DIV_W-2:0], qbit_d};
            remainder_q <= rem_d;
            dbz_q       <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divide8_unsigned_sequential.sv
// Directed and model-checked stimulus for the sequential 8-bit divider.
module tb_divide8_unsigned_sequential;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  divide8_unsigned_sequential dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from the current cycle and wait (bounded) for done.
  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eq, input logic [7:0] er, input logic edbz);
    int n;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      chk({tag, " busy"}, busy, (b != 0));
      tick();
      n++;
    end
    chk({tag, " latency"}, n, (b == 0) ? 0 : 8);
    chk({tag, " busy@done"}, busy, 1'b0);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " dbz"}, div_by_zero, edbz);
  endtask

  initial begin
    logic [7:0] a, b, prod_lo;
    int         n;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    chk("reset quotient", quotient, 8'h00);
    chk("reset remainder", remainder, 8'h00);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset dbz", div_by_zero, 1'b0);
    rst = 1'b0;
    tick();

    run("100/7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0);
    tick();
    chk("done one-cycle", done, 1'b0);
    chk("idle busy", busy, 1'b0);
    chk("hold quotient", quotient, 8'h0E);

    run("255/1", 8'd255, 8'd1, 8'hFF, 8'h00, 1'b0);
    run("128/255", 8'd128, 8'd255, 8'h00, 8'h80, 1'b0);
    run("0/9", 8'd0, 8'd9, 8'h00, 8'h00, 1'b0);
    run("255/255", 8'd255, 8'd255, 8'h01, 8'h00, 1'b0);

    tick();
    run("5/0", 8'd5, 8'd0, 8'hFF, 8'h05, 1'b1);
    tick();
    chk("div0 done pulse", done, 1'b0);
    run("6/3", 8'd6, 8'd3, 8'h02, 8'h00, 1'b0);

    // Back-to-back: issued during the DONE cycle of 6/3; old result must hold during CALC.
    dividend = 8'd200; divisor = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b accepted", busy, 1'b1);
    chk("b2b done low", done, 1'b0);
    chk("b2b hold quotient", quotient, 8'h02);
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("b2b latency", n, 8);
    chk("b2b quotient", quotient, 8'h16);
    chk("b2b remainder", remainder, 8'h02);
    tick();

    // Start held through CALC with changing operands must be ignored.
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    tick();
    n = 0;
    while (!done && n < 20) begin
      dividend = 8'd50 + 8'(n); divisor = 8'd3;
      tick(); n++;
    end
    start = 1'b0;
    chk("held start latency", n, 8);
    chk("held start quotient", quotient, 8'h0E);
    chk("held start remainder", remainder, 8'h02);
    tick();
    chk("held start idle", busy, 1'b0);
    chk("held start done low", done, 1'b0);

    // Reset at E4 of 200/3.
    dividend = 8'd200; divisor = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst quotient", quotient, 8'h00);
    chk("midrst remainder", remainder, 8'h00);
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst dbz", div_by_zero, 1'b0);
    tick();
    chk("midrst stays idle", done, 1'b0);
    run("200/3", 8'd200, 8'd3, 8'h42, 8'h02, 1'b0);
    tick();

    // Round trip with powers of two.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (i + j < 8) begin
          a = 8'(1 << i);
          b = 8'(1 << j);
          prod_lo = 8'((1 << i) * (1 << j));
          run($sformatf("rt %0d*%0d", a, b), prod_lo, b, a, 8'h00, 1'b0);
        end
      end
    end

    // Random pairs against the golden model.
    for (int k = 0; k < 150; k++) begin
      a = 8'($urandom_range(0, 255));
      b = (k % 25 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 0)
        run($sformatf("rnd %0d/%0d", a, b), a, b, 8'hFF, a, 1'b1);
      else
        run($sformatf("rnd %0d/%0d", a, b), a, b, a / b, a % b, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
